// File: rtl/muldiv_iter_if.sv
// Request/result bundle between the execute stage and the iterative M-extension unit.
// Ports: req_i/op_i/data1_i/data2_i/rd_addr_i/flush_i toward the unit;
//        ready_o/busy_o/res_valid_o/res_o/rd_addr_o back to the execute stage.
interface muldiv_iter_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  req_i;
  logic [2:0]            op_i;
  logic [XLEN-1:0]       data1_i;
  logic [XLEN-1:0]       data2_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  flush_i;
  logic                  ready_o;
  logic                  busy_o;
  logic                  res_valid_o;
  logic [XLEN-1:0]       res_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;

  // Execute stage side.
  modport master (
    output req_i, op_i, data1_i, data2_i, rd_addr_i, flush_i,
    input  ready_o, busy_o, res_valid_o, res_o, rd_addr_o
  );

  // Arithmetic unit side.
  modport slave (
    input  req_i, op_i, data1_i, data2_i, rd_addr_i, flush_i,
    output ready_o, busy_o, res_valid_o, res_o, rd_addr_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: N+2 edges after acceptance (N = XLEN/BITS_PER_CYCLE); div-by-zero/overflow 1 edge.
// Backpressure: ready_o only in IDLE, requests while busy are dropped; flush_i aborts silently.
// Ports: clk, rst_n (async active-low), bus (muldiv_iter_if.slave).
// Optional macro MULDIV_REM_CACHE_EN: last-divide result cache, hits return after the accepting edge.
module muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int REG_ADDR_W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_iter_if.slave bus
);
  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_POST, S_SPECIAL} state_e;
  state_e state_q, state_d;

  logic [2:0]            op_q, op_d;
  logic [XLEN-1:0]       opa_q, opa_d, opb_q, opb_d;   // operands as received
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       a_q, a_d;       // multiplier bits / dividend shifting into quotient
  logic [2*XLEN-1:0]     b_q, b_d;       // shifted multiplicand / divisor in the low half
  logic [2*XLEN-1:0]     acc_q, acc_d;   // product / partial remainder in [XLEN:0]
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic                  res_valid_q, res_valid_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic [REG_ADDR_W-1:0] rdo_q, rdo_d;

`ifdef MULDIV_REM_CACHE_EN
  logic            c_vld_q, c_vld_d, c_sgn_q, c_sgn_d;
  logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
  logic            cache_hit;
  assign cache_hit = bus.op_i[2] && c_vld_q && (c_a_q == bus.data1_i) &&
                     (c_b_q == bus.data2_i) && (c_sgn_q == !bus.op_i[0]);
`endif

  logic accept, div_zero_i, div_ovf_i;
  assign accept     = bus.req_i && (state_q == S_IDLE) && !bus.flush_i;
  assign div_zero_i = (bus.data2_i == '0);
  assign div_ovf_i  = !bus.op_i[0] && (bus.data1_i == MIN_VAL) && (bus.data2_i == '1);

  // Operand signedness: MULH, MULHSU(rs1 only), DIV, REM.
  logic sgn_a, sgn_b, neg_a, neg_b;
  assign sgn_a = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
  assign sgn_b = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
  assign neg_a = sgn_a && opa_q[XLEN-1];
  assign neg_b = sgn_b && opb_q[XLEN-1];

  // Magnitudes are unsigned XLEN: |MIN| = 2^(XLEN-1) still fits, so no widening is needed.
  logic [2*XLEN-1:0] digit, prod;
  logic [XLEN-1:0]   quo_s, rem_s;
  assign digit = {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, a_q[BITS_PER_CYCLE-1:0]};
  assign prod  = neg_res_q ? -acc_q : acc_q;
  assign quo_s = neg_res_q ? -a_q : a_q;
  assign rem_s = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

  // One radix-2^BITS_PER_CYCLE quotient digit as BITS_PER_CYCLE restoring steps.
  logic [XLEN:0]   rem_t;
  logic [XLEN-1:0] quo_t;
  always_comb begin
    rem_t = acc_q[XLEN:0];
    quo_t = a_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_t = {rem_t[XLEN-1:0], quo_t[XLEN-1]};
      quo_t = {quo_t[XLEN-2:0], 1'b0};
      if (rem_t >= {1'b0, b_q[XLEN-1:0]}) begin
        rem_t    = rem_t - {1'b0, b_q[XLEN-1:0]};
        quo_t[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    res_valid_d = 1'b0;
    res_d       = res_q;
    rdo_d       = rdo_q;
`ifdef MULDIV_REM_CACHE_EN
    c_vld_d = c_vld_q;
    c_sgn_d = c_sgn_q;
    c_a_d   = c_a_q;
    c_b_d   = c_b_q;
    c_quo_d = c_quo_q;
    c_rem_d = c_rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus.op_i;
          opa_d = bus.data1_i;
          opb_d = bus.data2_i;
          rd_d  = bus.rd_addr_i;
          if (bus.op_i[2] && (div_zero_i || div_ovf_i)) begin
            state_d = S_SPECIAL;
          end
`ifdef MULDIV_REM_CACHE_EN
          else if (cache_hit) begin
            res_valid_d = 1'b1;
            res_d       = bus.op_i[1] ? c_rem_q : c_quo_q;
            rdo_d       = bus.rd_addr_i;
          end
`endif
          else begin
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        a_d       = neg_a ? -opa_q : opa_q;
        b_d       = {{XLEN{1'b0}}, (neg_b ? -opb_q : opb_q)};
        acc_d     = '0;
        cnt_d     = CNT_W'(N - 1);
        neg_res_d = neg_a ^ neg_b;
        neg_rem_d = neg_a;
        state_d   = S_CALC;
      end
      S_CALC: begin
        if (op_q[2]) begin
          a_d   = quo_t;
          acc_d = {{(XLEN-1){1'b0}}, rem_t};
        end else begin
          acc_d = acc_q + b_q * digit;
          a_d   = a_q >> BITS_PER_CYCLE;
          b_d   = b_q << BITS_PER_CYCLE;
        end
        if (cnt_q == '0) begin
          state_d = S_POST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_POST: begin
        unique case (op_q)
          3'b000:                 res_d = prod[XLEN-1:0];
          3'b001, 3'b010, 3'b011: res_d = prod[2*XLEN-1:XLEN];
          3'b100, 3'b101:         res_d = quo_s;
          default:                res_d = rem_s;
        endcase
        rdo_d       = rd_q;
        res_valid_d = 1'b1;
        state_d     = S_IDLE;
`ifdef MULDIV_REM_CACHE_EN
        if (op_q[2]) begin
          c_vld_d = 1'b1;
          c_sgn_d = !op_q[0];
          c_a_d   = opa_q;
          c_b_d   = opb_q;
          c_quo_d = quo_s;
          c_rem_d = rem_s;
        end
`endif
      end
      S_SPECIAL: begin
        if (opb_q == '0) res_d = op_q[1] ? opa_q : '1;
        else             res_d = op_q[1] ? '0 : MIN_VAL;
        rdo_d       = rd_q;
        res_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a completing POST/SPECIAL.
    if ((state_q != S_IDLE) && bus.flush_i) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      res_d       = res_q;
      rdo_d       = rdo_q;
`ifdef MULDIV_REM_CACHE_EN
      if (op_q[2]) c_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      rdo_q       <= '0;
`ifdef MULDIV_REM_CACHE_EN
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      rdo_q       <= rdo_d;
`ifdef MULDIV_REM_CACHE_EN
      c_vld_q <= c_vld_d;
      c_sgn_q <= c_sgn_d;
      c_a_q   <= c_a_d;
      c_b_q   <= c_b_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
`endif
    end
  end

  assign bus.ready_o     = (state_q == S_IDLE);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_o       = res_q;
  assign bus.rd_addr_o   = rdo_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter in the default configuration (XLEN=32, 1 bit/cycle).
// Latency is counted in rising edges after the accepting edge; outputs sampled on the falling edge.
module tb_muldiv_iter;
  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int RAW  = 5;
  localparam int LAT  = XLEN / BPC + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_iter_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) bus ();

  muldiv_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .REG_ADDR_W(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic seen;
  int   lat, bcyc;

  localparam logic [2:0]  MUL_OP [7] = '{3'b001, 3'b011, 3'b000, 3'b010, 3'b000, 3'b001, 3'b010};
  localparam logic [31:0] MUL_A  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                         32'd7, 32'h80000000, 32'h80000000};
  localparam logic [31:0] MUL_B  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002,
                                         32'd6, 32'h80000000, 32'hFFFFFFFF};
  localparam logic [31:0] MUL_E  [7] = '{32'h00000000, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF,
                                         32'h0000002A, 32'h40000000, 32'h80000000};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.req_i     = 1'b1;
    bus.op_i      = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    bus.rd_addr_i = rd;
    step();
    bus.req_i = 1'b0;
  endtask

  // Bounded wait for the result strobe; counts edges and busy samples before it.
  task automatic wait_result(input int limit, output logic got, output int edges, output int busy_cycles);
    got = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (!got && edges < limit) begin
      if (bus.res_valid_o) got = 1'b1;
      else begin
        if (bus.busy_o) busy_cycles++;
        step();
        edges++;
      end
    end
    if (bus.res_valid_o) got = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_i = 0; bus.op_i = 0; bus.data1_i = 0; bus.data2_i = 0; bus.rd_addr_i = 0; bus.flush_i = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.res_valid_o); end
    checks++; if (bus.res_o !== 32'h0) begin errors++; $display("FAIL reset_res: got %h expected 00000000", bus.res_o); end
    checks++; if (bus.rd_addr_o !== 5'h0) begin errors++; $display("FAIL reset_rd: got %h expected 00", bus.rd_addr_o); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", bus.ready_o); end
  endtask

  task automatic test_divide();
    issue(3'b100, 32'd20, 32'hFFFFFFFD, 5'd5);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL div_strobe: got %b expected 1", seen); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bcyc != LAT) begin errors++; $display("FAIL div_busy: got %0d expected %0d", bcyc, LAT); end
    checks++; if (bus.res_o !== 32'hFFFFFFFA) begin errors++; $display("FAIL div_20_m3: got %h expected FFFFFFFA", bus.res_o); end
    checks++; if (bus.rd_addr_o !== 5'd5) begin errors++; $display("FAIL div_rd: got %0d expected 5", bus.rd_addr_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL div_ready_at_strobe: got %b expected 1", bus.ready_o); end
    step();
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL div_strobe_width: got %b expected 0", bus.res_valid_o); end
    step();
    checks++; if (bus.res_o !== 32'hFFFFFFFA) begin errors++; $display("FAIL div_res_hold: got %h expected FFFFFFFA", bus.res_o); end

    issue(3'b110, 32'd20, 32'hFFFFFFFD, 5'd6);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'h00000002) begin errors++; $display("FAIL rem_20_m3: got %h seen %b expected 00000002", bus.res_o, seen); end
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd7);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2: got %h seen %b expected FFFFFFFD", bus.res_o, seen); end
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd7);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2: got %h seen %b expected FFFFFFFF", bus.res_o, seen); end
    issue(3'b101, 32'd100, 32'd7, 5'd8);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h seen %b expected 0000000E", bus.res_o, seen); end
    issue(3'b111, 32'd100, 32'd7, 5'd8);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h seen %b expected 00000002", bus.res_o, seen); end
  endtask

  task automatic test_div_zero();
    issue(3'b101, 32'h1234, 32'h0, 5'd10);
    wait_result(10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by_zero: got %h seen %b expected FFFFFFFF", bus.res_o, seen); end
    checks++; if (lat != 1) begin errors++; $display("FAIL divz_latency: got %0d expected 1", lat); end
    checks++; if (bcyc != 1) begin errors++; $display("FAIL divz_busy: got %0d expected 1", bcyc); end
    checks++; if (bus.rd_addr_o !== 5'd10) begin errors++; $display("FAIL divz_rd: got %0d expected 10", bus.rd_addr_o); end
    issue(3'b110, 32'h1234, 32'h0, 5'd11);
    wait_result(10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'h00001234 || lat != 1) begin errors++; $display("FAIL rem_by_zero: got %h lat %0d expected 00001234 lat 1", bus.res_o, lat); end
    issue(3'b100, 32'hFFFFFFFB, 32'h0, 5'd11);
    wait_result(10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_by_zero: got %h seen %b expected FFFFFFFF", bus.res_o, seen); end
  endtask

  task automatic test_overflow();
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12);
    wait_result(10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'h80000000 || lat != 1) begin errors++; $display("FAIL div_overflow: got %h lat %0d expected 80000000 lat 1", bus.res_o, lat); end
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13);
    wait_result(10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'h00000000 || lat != 1) begin errors++; $display("FAIL rem_overflow: got %h lat %0d expected 00000000 lat 1", bus.res_o, lat); end
  endtask

  task automatic test_mul();
    for (int i = 0; i < 7; i++) begin
      issue(MUL_OP[i], MUL_A[i], MUL_B[i], 5'(i + 1));
      wait_result(LAT + 10, seen, lat, bcyc);
      checks++;
      if (!seen || bus.res_o !== MUL_E[i] || lat != LAT) begin
        errors++;
        $display("FAIL mul_vec%0d: got %h lat %0d expected %h lat %0d", i, bus.res_o, lat, MUL_E[i], LAT);
      end
    end
  endtask

  task automatic test_flush();
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    repeat (10) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle: got ready %b busy %b expected 1 0", bus.ready_o, bus.busy_o); end
    wait_result(LAT + 5, seen, lat, bcyc);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_strobe: got %b expected 0", seen); end
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'd14 || bus.rd_addr_o !== 5'd9) begin errors++; $display("FAIL flush_retry: got %h rd %0d expected 0000000E rd 9", bus.res_o, bus.rd_addr_o); end

    // Flush sampled on the same edge that would end POST.
    issue(3'b000, 32'd3, 32'd5, 5'd15);
    repeat (LAT - 1) step();
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL flush_post_busy: got %b expected 1", bus.busy_o); end
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    checks++; if (bus.res_valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin errors++; $display("FAIL flush_post: got valid %b ready %b expected 0 1", bus.res_valid_o, bus.ready_o); end
    checks++; if (bus.res_o !== 32'd14 || bus.rd_addr_o !== 5'd9) begin errors++; $display("FAIL flush_post_hold: got %h rd %0d expected 0000000E rd 9", bus.res_o, bus.rd_addr_o); end

    // Flush in IDLE blocks a coincident request.
    bus.flush_i = 1'b1;
    issue(3'b101, 32'd50, 32'd5, 5'd1);
    bus.flush_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle_priority: got busy %b expected 0", bus.busy_o); end
    wait_result(5, seen, lat, bcyc);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_idle_strobe: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_first: got %h expected FFFFFFFE", bus.res_o); end
    issue(3'b000, 32'd7, 32'd6, 5'd2);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'h2A || bus.rd_addr_o !== 5'd2 || lat != LAT) begin errors++; $display("FAIL b2b_second: got %h rd %0d lat %0d expected 0000002A rd 2 lat %0d", bus.res_o, bus.rd_addr_o, lat, LAT); end
  endtask

  task automatic test_busy_ignored();
    issue(3'b101, 32'd100, 32'd7, 5'd4);
    repeat (3) step();
    issue(3'b000, 32'd2, 32'd3, 5'd7);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'd14 || bus.rd_addr_o !== 5'd4 || lat != LAT - 4) begin errors++; $display("FAIL busy_ignore: got %h rd %0d lat %0d expected 0000000E rd 4 lat %0d", bus.res_o, bus.rd_addr_o, lat, LAT - 4); end
    step();
    wait_result(LAT + 5, seen, lat, bcyc);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_no_queue: got %b expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    issue(3'b100, 32'd20, 32'hFFFFFFFD, 5'd5);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_state: got busy %b ready %b valid %b expected 0 1 0", bus.busy_o, bus.ready_o, bus.res_valid_o); end
    checks++; if (bus.res_o !== 32'h0 || bus.rd_addr_o !== 5'h0) begin errors++; $display("FAIL midreset_outputs: got %h rd %0d expected 00000000 rd 0", bus.res_o, bus.rd_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(3'b101, 32'd100, 32'd7, 5'd6);
    wait_result(LAT + 10, seen, lat, bcyc);
    checks++; if (!seen || bus.res_o !== 32'd14 || lat != LAT) begin errors++; $display("FAIL midreset_recover: got %h lat %0d expected 0000000E lat %0d", bus.res_o, lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_overflow();
    test_mul();
    test_flush();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
